// File: rtl/logicnet_lut_pkg.sv
// ============================================================================
// Module   : logicnet_lut_pkg
// Purpose  : Shared definitions for the runtime-programmable LogicNet neuron.
//            Default table geometry, the load-FSM state type and a helper
//            that derives the table depth from the address width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package logicnet_lut_pkg;

  // Default lookup address width (concatenated quantised inputs)
  localparam int LUT_IN_BITS  = 6;
  // Default width of one table entry / neuron output
  localparam int LUT_OUT_BITS = 2;

  // Configuration FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } lut_state_e;

  // Number of truth-table entries for a given address width
  function automatic int lut_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage : logicnet_lut_pkg

`default_nettype wire

// File: rtl/lut_dist_ram.sv
// ============================================================================
// Module   : lut_dist_ram
// Purpose  : Truth-table storage, DEPTH x DATA_BITS, intended for LUT-based
//            distributed RAM. Contents are not reset.
// Ports    : clk   - clock
//            we    - synchronous write enable
//            waddr - write address
//            wdata - write data
//            raddr - asynchronous read address
//            rdata - asynchronous read data (registered by the caller)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_dist_ram
  import logicnet_lut_pkg::*;
#(
  parameter int ADDR_BITS = LUT_IN_BITS,
  parameter int DATA_BITS = LUT_OUT_BITS,
  parameter int DEPTH     = lut_depth(ADDR_BITS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  (* rom_style = "distributed", ram_style = "distributed" *)
  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read keeps the lookup path to a single register stage
  assign rdata = mem[raddr];

endmodule : lut_dist_ram

`default_nettype wire

// File: rtl/logicnet_lut_loader.sv
// ============================================================================
// Module   : logicnet_lut_loader
// Purpose  : Runtime-programmable LogicNet neuron. A 2^IN_BITS x OUT_BITS
//            truth table is streamed in over a valid/ready configuration
//            port and answered to upstream lookups with a registered result.
// Ports    : clk          - clock
//            rst_n        - asynchronous active-low reset
//            cfg_start    - pulse: begin (or restart) a full table load
//            cfg_valid    - cfg_data valid
//            cfg_ready    - load beat accepted this cycle when valid
//            cfg_data     - table entry for the current load address
//            cfg_done     - pulse after the final entry is written
//            cfg_abort    - pulse when an in-progress load is restarted
//            table_loaded - a complete table is present
//            M0           - lookup address
//            in_valid     - M0 valid
//            M1           - registered lookup result
//            out_valid    - M1 valid
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logicnet_lut_loader
  import logicnet_lut_pkg::*;
#(
  parameter int IN_BITS  = LUT_IN_BITS,
  parameter int OUT_BITS = LUT_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_done,
  output logic                cfg_abort,
  output logic                table_loaded,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                in_valid,
  output logic [OUT_BITS-1:0] M1,
  output logic                out_valid
);

  localparam int DEPTH = lut_depth(IN_BITS);

  lut_state_e          state;
  lut_state_e          state_nxt;
  logic [IN_BITS-1:0]  addr;
  logic [IN_BITS-1:0]  addr_nxt;
  logic                done_nxt;
  logic                abort_nxt;
  logic                loaded_nxt;
  logic                wr_en;
  logic                last_addr;
  logic                lookup_fire;
  logic [OUT_BITS-1:0] rd_data;

  assign last_addr = (addr == IN_BITS'(DEPTH - 1));

  // Next-state / output logic
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    done_nxt   = 1'b0;
    abort_nxt  = 1'b0;
    loaded_nxt = table_loaded;
    wr_en      = 1'b0;
    cfg_ready  = 1'b0;

    case (state)
      ST_IDLE: begin
        // cfg_valid is ignored here, even alongside cfg_start
        if (cfg_start) begin
          state_nxt  = ST_LOAD;
          addr_nxt   = '0;
          loaded_nxt = 1'b0;
        end
      end

      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          // Restart wins over a coincident beat: that beat is dropped
          addr_nxt  = '0;
          abort_nxt = 1'b1;
        end else if (cfg_valid) begin
          wr_en    = 1'b1;
          addr_nxt = addr + IN_BITS'(1);
          if (last_addr) begin
            state_nxt  = ST_IDLE;
            done_nxt   = 1'b1;
            loaded_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Configuration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr         <= '0;
      cfg_done     <= 1'b0;
      cfg_abort    <= 1'b0;
      table_loaded <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr         <= addr_nxt;
      cfg_done     <= done_nxt;
      cfg_abort    <= abort_nxt;
      table_loaded <= loaded_nxt;
    end
  end

  // Lookups are only served from a complete table outside of a load, so
  // reads never overlap writes.
  assign lookup_fire = in_valid && table_loaded && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M1        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= lookup_fire;
      if (lookup_fire) begin
        M1 <= rd_data;
      end
    end
  end

  lut_dist_ram #(
    .ADDR_BITS (IN_BITS),
    .DATA_BITS (OUT_BITS),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (addr),
    .wdata (cfg_data),
    .raddr (M0),
    .rdata (rd_data)
  );

endmodule : logicnet_lut_loader

`default_nettype wire

// File: tb/tb_logicnet_lut_loader.sv
// ============================================================================
// Module   : tb_logicnet_lut_loader
// Purpose  : Self-checking bench for logicnet_lut_loader. Table-driven lookup
//            vectors, hand-written load/restart/reset sequences and random
//            loads/lookups checked against an array model of the table.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logicnet_lut_loader;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 2;
  localparam int DEPTH    = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data = '0;
  logic                cfg_done;
  logic                cfg_abort;
  logic                table_loaded;
  logic [IN_BITS-1:0]  M0 = '0;
  logic                in_valid = 1'b0;
  logic [OUT_BITS-1:0] M1;
  logic                out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: table contents, completeness flag, last result
  logic [OUT_BITS-1:0] stim      [DEPTH];
  logic [OUT_BITS-1:0] model_tbl [DEPTH];
  bit                  model_loaded = 1'b0;
  logic [OUT_BITS-1:0] last_m1 = '0;

  typedef struct {
    logic [IN_BITS-1:0]  addr;
    logic [OUT_BITS-1:0] exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  logicnet_lut_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_done     (cfg_done),
    .cfg_abort    (cfg_abort),
    .table_loaded (table_loaded),
    .M0           (M0),
    .in_valid     (in_valid),
    .M1           (M1),
    .out_valid    (out_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One lookup cycle; only called while the block is idle
  task automatic lookup(input logic [IN_BITS-1:0] a, input bit v, input string tag);
    bit exp_v;
    M0       = a;
    in_valid = v;
    tick();
    in_valid = 1'b0;
    exp_v = v && model_loaded;
    if (exp_v) last_m1 = model_tbl[a];
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(exp_v));
    chk({tag, "_M1"}, 32'(M1), 32'(last_m1));
  endtask

  // Start (or restart) a load and stream nbeats entries from stim[].
  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
  task automatic do_load(input int mode, input bit start_valid, input bit exp_abort,
                         input int nbeats);
    int k = 0;
    int cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    bit ready_ok = 1'b1;
    bit quiet_ok = 1'b1;
    bit tl_ok = 1'b1;
    bit v;
    cfg_start = 1'b1;
    cfg_valid = start_valid;
    cfg_data  = stim[0] ^ 2'b11;
    in_valid  = 1'b0;
    tick();
    cfg_start = 1'b0;
    model_loaded = 1'b0;
    chk("start_abort", 32'(cfg_abort), 32'(exp_abort));
    chk("start_table_loaded", 32'(table_loaded), 32'd0);
    while (k < nbeats && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = ($urandom % 3) != 0;
      endcase
      cfg_valid = v;
      cfg_data  = v ? stim[k] : OUT_BITS'($urandom);
      in_valid  = $urandom_range(0, 1) == 1;
      M0        = IN_BITS'($urandom);
      if (cfg_ready !== 1'b1) ready_ok = 1'b0;
      tick();
      cyc++;
      if (out_valid !== 1'b0 || M1 !== last_m1) quiet_ok = 1'b0;
      if (!(v && k == DEPTH - 1) && table_loaded !== 1'b0) tl_ok = 1'b0;
      if (cfg_done === 1'b1) done_cnt++;
      if (cfg_abort === 1'b1) abort_cnt++;
      if (v) begin
        model_tbl[k] = stim[k];
        k++;
      end
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    chk("load_beats_within_budget", 32'(k), 32'(nbeats));
    chk("ready_held_in_load", 32'(ready_ok), 32'd1);
    chk("no_lookup_during_load", 32'(quiet_ok), 32'd1);
    chk("table_loaded_low_in_load", 32'(tl_ok), 32'd1);
    chk("no_abort_during_beats", 32'(abort_cnt), 32'd0);
    if (nbeats == DEPTH) begin
      chk("done_after_last_beat", 32'(cfg_done), 32'd1);
      chk("done_pulse_count", 32'(done_cnt), 32'd1);
      chk("table_loaded_after_done", 32'(table_loaded), 32'd1);
      chk("ready_low_after_done", 32'(cfg_ready), 32'd0);
      model_loaded = 1'b1;
    end
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < 6; i++) begin
      lookup(vecs[i].addr, 1'b1, tag);
      chk({tag, "_vec"}, 32'(M1), 32'(vecs[i].exp));
      if (i == 0) chk({tag, "_done_one_cycle"}, 32'(cfg_done), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{6'h00, 2'd0};
    vecs[1] = '{6'h07, 2'd3};
    vecs[2] = '{6'h3F, 2'd3};
    vecs[3] = '{6'h12, 2'd2};
    vecs[4] = '{6'h21, 2'd1};
    vecs[5] = '{6'h2A, 2'd2};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_cfg_abort", 32'(cfg_abort), 32'd0);
    chk("rst_table_loaded", 32'(table_loaded), 32'd0);
    chk("rst_M1", 32'(M1), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    lookup(6'h11, 1'b1, "lookup_before_load");
    chk("not_loaded_after_reset", 32'(table_loaded), 32'd0);

    // Entry k = k[1:0]; first vector lookup lands in the cfg_done cycle
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'(k);
    do_load(0, 1'b0, 1'b0, DEPTH);
    run_vectors("mod4_table");

    // Same table with valid toggling every other cycle
    do_load(1, 1'b0, 1'b0, DEPTH);
    run_vectors("toggled_table");
    lookup(6'h05, 1'b0, "idle_no_valid");

    // Restart after 20 beats, then a full pass of 2'b10
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'($urandom);
    do_load(0, 1'b0, 1'b0, 20);
    for (int k = 0; k < DEPTH; k++) stim[k] = 2'b10;
    do_load(0, 1'b1, 1'b1, DEPTH);
    begin
      bit all_ok = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
        lookup(IN_BITS'(a), 1'b1, "restart_lookup");
        if (M1 !== 2'b10) all_ok = 1'b0;
      end
      chk("restart_all_entries_10", 32'(all_ok), 32'd1);
    end

    // Reset in the middle of a reload over a valid table
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'($urandom);
    do_load(0, 1'b0, 1'b0, 40);
    rst_n = 1'b0;
    #1;
    chk("midload_rst_table_loaded", 32'(table_loaded), 32'd0);
    chk("midload_rst_ready", 32'(cfg_ready), 32'd0);
    chk("midload_rst_M1", 32'(M1), 32'd0);
    last_m1 = '0;
    model_loaded = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) lookup(IN_BITS'($urandom), 1'b1, "after_midload_rst");
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'($urandom);
    do_load(2, 1'b0, 1'b0, DEPTH);
    for (int a = 0; a < DEPTH; a++) lookup(IN_BITS'(a), 1'b1, "reloaded");

    // cfg_start with cfg_valid in idle: the start-cycle data is dropped
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'($urandom);
    do_load(0, 1'b1, 1'b0, DEPTH);
    begin
      logic [OUT_BITS-1:0] first_beat;
      first_beat = stim[0];
      lookup(6'h00, 1'b1, "start_valid_entry0");
      chk("entry0_is_first_beat", 32'(M1), 32'(first_beat));
    end
    for (int a = 1; a < DEPTH; a++) lookup(IN_BITS'(a), 1'b1, "start_valid_table");

    // Random loads and random lookup traffic
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'($urandom);
      do_load(2, $urandom_range(0, 1) == 1, 1'b0, DEPTH);
      for (int i = 0; i < 80; i++)
        lookup(IN_BITS'($urandom), $urandom_range(0, 3) != 0, "random_lookup");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_logicnet_lut_loader

`default_nettype wire
